// File: rtl/imdct_long_engine.sv
// rtl/imdct_long_engine.sv - 36-point long-block IMDCT engine, x[n] = sum_k X[k]*C[n][k]
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start                  begin one frame (sampled only when idle)
//   busy, done             frame in progress / one-cycle completion pulse
//   rom_enable/rom_n/rom_k cosine ROM read strobe and {n,k} address; rom_data one cycle later
//   smp_rd_en/smp_addr     sample buffer read strobe and index k; smp_data one cycle later
//   out_valid/out_ready    result stream handshake
//   out_index/out_data     n of the current result and saturated x[n]
module imdct_long_engine #(
    parameter int DATA_W    = 18,
    parameter int FRAC_BITS = 16,
    parameter int N_OUT     = 36,
    parameter int N_IN      = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rom_enable,
    output logic [5:0]        rom_n,
    output logic [4:0]        rom_k,
    input  logic [DATA_W-1:0] rom_data,
    output logic              smp_rd_en,
    output logic [4:0]        smp_addr,
    input  logic [DATA_W-1:0] smp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_index,
    output logic [DATA_W-1:0] out_data
);

    localparam int PROD_W = 2 * DATA_W;
    // 18 products of 2*DATA_W bits need 5 extra headroom bits
    localparam int ACC_W  = PROD_W + 5;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t                    state_q;
    logic [5:0]                n_q;
    logic [4:0]                k_q;
    logic                      drain_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      rd_q;
    logic                      out_valid_q;
    logic [5:0]                out_index_q;
    logic [DATA_W-1:0]         out_data_q;
    logic signed [ACC_W-1:0]   acc_q;

    // Datapath pipeline: read issued (rd_q) -> data returned (rd_d1_q) -> product registered
    logic                      rd_d1_q;
    logic                      prod_vld_q;
    logic signed [PROD_W-1:0]  prod_q;

    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   acc_shift;
    logic [DATA_W-1:0]         sat_val;

    assign busy       = busy_q;
    assign done       = done_q;
    assign rom_enable = rd_q;
    assign smp_rd_en  = rd_q;
    assign rom_n      = n_q;
    assign rom_k      = k_q;
    assign smp_addr   = k_q;
    assign out_valid  = out_valid_q;
    assign out_index  = out_index_q;
    assign out_data   = out_data_q;

    // Accumulator value including the product landing this cycle; the final
    // DRAIN cycle uses it so the last product reaches the result without an extra cycle.
    always_comb begin
        acc_d = acc_q;
        if (prod_vld_q) begin
            acc_d = acc_q + {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
        end
        acc_shift = acc_d >>> FRAC_BITS;
        if (acc_shift > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (acc_shift < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_val = acc_shift[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_d1_q    <= 1'b0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
        end else begin
            rd_d1_q    <= rd_q;
            prod_vld_q <= rd_d1_q;
            prod_q     <= $signed(rom_data) * $signed(smp_data);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            acc_q       <= '0;
        end else begin
            acc_q <= acc_d;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_ISSUE;
                        busy_q  <= 1'b1;
                        n_q     <= '0;
                        k_q     <= '0;
                        rd_q    <= 1'b1;
                        acc_q   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (k_q == 5'(N_IN - 1)) begin
                        state_q <= S_DRAIN;
                        rd_q    <= 1'b0;
                        drain_q <= 1'b0;
                    end else begin
                        k_q <= k_q + 5'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q) begin
                        state_q     <= S_OUT;
                        out_valid_q <= 1'b1;
                        out_index_q <= n_q;
                        out_data_q  <= sat_val;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (n_q == 6'(N_OUT - 1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_ISSUE;
                            n_q     <= n_q + 6'd1;
                            k_q     <= '0;
                            rd_q    <= 1'b1;
                            acc_q   <= '0;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imdct_long_engine.sv
// tb/tb_imdct_long_engine.sv - self-checking bench for imdct_long_engine against a sum-of-products model
module tb_imdct_long_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, rom_enable, smp_rd_en, out_valid;
    logic [5:0]  rom_n, out_index;
    logic [4:0]  rom_k, smp_addr;
    logic [17:0] rom_data, smp_data, out_data;
    logic        out_ready = 1'b1;

    imdct_long_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rom_enable (rom_enable),
        .rom_n      (rom_n),
        .rom_k      (rom_k),
        .rom_data   (rom_data),
        .smp_rd_en  (smp_rd_en),
        .smp_addr   (smp_addr),
        .smp_data   (smp_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    int     coef [0:35][0:17];
    int     xs   [0:17];
    longint exp_v [0:35];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // ROM and sample buffer: registered reads, one cycle latency
    always @(posedge clk) begin
        if (rom_enable) rom_data <= coef[rom_n][rom_k][17:0];
        if (smp_rd_en)  smp_data <= xs[smp_addr][17:0];
    end

    int cyc = 0;
    int cyc0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          got_cnt = 0;
    int          got_idx  [0:35];
    int          got_data [0:35];
    int          got_cyc  [0:35];
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          stall_en = 0;
    int          stall_cnt = 0;
    logic [17:0] held;
    bit          chk_resume = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (chk_resume) begin
                check("resume_rom_enable", rom_enable, 1);
                check("resume_rom_n", rom_n, 6);
                chk_resume = 0;
            end
            if (stall_en && out_valid && out_index == 6'd5 && stall_cnt < 10) begin
                out_ready = 1'b0;
                if (stall_cnt == 0) begin
                    held = out_data;
                end else begin
                    check("stall_valid", out_valid, 1);
                    check("stall_index", out_index, 5);
                    check("stall_data", out_data, held);
                    check("stall_rom_enable", rom_enable, 0);
                end
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (got_cnt < 36) begin
                    got_idx[got_cnt]  = out_index;
                    got_data[got_cnt] = $signed(out_data);
                    got_cyc[got_cnt]  = cyc - cyc0;
                end
                if (stall_en && out_index == 6'd5) chk_resume = 1;
                got_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - cyc0;
            end
        end
    end

    function automatic void compute_expected();
        for (int n = 0; n < 36; n++) begin
            longint s = 0;
            longint q;
            for (int k = 0; k < 18; k++) s += longint'(coef[n][k]) * longint'(xs[k]);
            q = s >>> 16;
            if (q > 131071) q = 131071;
            if (q < -131072) q = -131072;
            exp_v[n] = q;
        end
    endfunction

    function automatic void load_const(input int c, input int x);
        for (int n = 0; n < 36; n++)
            for (int k = 0; k < 18; k++) coef[n][k] = c;
        for (int k = 0; k < 18; k++) xs[k] = x;
    endfunction

    function automatic void load_cos_random();
        real pi = 3.14159265358979;
        for (int n = 0; n < 36; n++)
            for (int k = 0; k < 18; k++)
                coef[n][k] = $rtoi($floor(65536.0 * $cos(pi / 72.0 * real'((2 * n + 1 + 18) * (2 * k + 1))) + 0.5));
        for (int k = 0; k < 18; k++) xs[k] = int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic run_frame(input string tag, input bit timing);
        got_cnt   = 0;
        done_cnt  = 0;
        stall_cnt = 0;
        compute_expected();
        @(posedge clk); #1;
        cyc0  = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        if (timing) begin
            repeat (99) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
        check({tag, "_done_seen"}, done_cnt, 1);
        repeat (30) @(posedge clk);
        #1;
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_out_count"}, got_cnt, 36);
        check({tag, "_busy_after"}, busy, 0);
        for (int n = 0; n < 36; n++) begin
            check($sformatf("%s_idx%0d", tag, n), got_idx[n], n);
            check($sformatf("%s_x%0d", tag, n), got_data[n], exp_v[n]);
        end
        if (timing) begin
            check("t_valid_n0", got_cyc[0], 21);
            check("t_valid_n1", got_cyc[1], 42);
            check("t_valid_n35", got_cyc[35], 756);
            check("t_done", done_cyc, 757);
        end
    endtask

    initial begin
        int  pre_cnt;
        bit  hit;
        reset = 1'b1;
        start = 1'b0;
        load_const(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_enable", rom_enable, 0);
        check("rst_smp_rd_en", smp_rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_rom_n", rom_n, 0);
        check("rst_rom_k", rom_k, 0);
        check("rst_smp_addr", smp_addr, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;

        load_const(65536, 1000);
        check("model_const", 64'(exp_v[0] * 0 + 18000), 18000);
        run_frame("const", 1'b1);

        load_cos_random();
        stall_en = 1;
        run_frame("cos_stall", 1'b0);
        stall_en = 0;
        check("stall_cycles", stall_cnt, 10);

        load_const(65535, 131071);
        run_frame("sat_pos", 1'b0);
        load_const(65535, -131072);
        run_frame("sat_neg", 1'b0);

        load_cos_random();
        got_cnt  = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            if (rom_enable && rom_n == 6'd10) hit = 1;
        end
        check("rst_mid_reached", hit, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rom_enable", rom_enable, 0);
        check("rst_mid_rom_n", rom_n, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 0);
        pre_cnt = got_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("rst_mid_no_outputs", got_cnt, pre_cnt);
        check("rst_mid_no_done", done_cnt, 0);
        run_frame("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
